sys_ctrl: RTL and testbench
===========================

# sys_ctrl

Run controller for the simple computer. Owns the program-load / execute / read-back sequence. While the processor is held in reset, a host port can fill instruction memory and data memory. On a RUN command the controller releases the processor and gives it the data-memory port. Halt is detected from the instruction address; a cycle budget bounds every run. After the run, data memory is handed back to the host for read-back.

## Interface
Parameters:
- `HALT_CYCLES`, default 4: consecutive cycles with unchanged `cpu_instr_addr` that declare a halt (jump-to-self).
- `MAX_CYCLES`, default 1000: run cycle budget before forced stop.
- `RD_LAT`, default 1: data-memory read latency in cycles.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `host_valid` in 1: host command valid.
- `host_ready` out 1: command accepted when `host_valid & host_ready`.
- `host_cmd` in 2: 0 WR_I, 1 WR_D, 2 RD_D, 3 RUN.
- `host_addr` in 8: target address.
- `host_wdata` in 32: write data; WR_I uses [11:0].
- `rd_valid` out 1: one-cycle pulse, `rd_data` valid.
- `rd_data` out 32: read-back word.
- `done` out 1: one-cycle pulse at end of run.
- `timeout` out 1: sticky; last run hit `MAX_CYCLES`.
- `cycle_count` out 32: cycles spent in last/current run.
- `cpu_rst` out 1: processor reset.
- `cpu_instr_addr` in 8: processor fetch address.
- `cpu_mem_wr` in 1, `cpu_mem_addr` in 8, `cpu_mem_data` in 32: processor data-memory request.
- `imem_wr` out 1, `imem_addr` out 8, `imem_wdata` out 12: instruction-memory write port.
- `dmem_wr` out 1, `dmem_addr` out 8, `dmem_wdata` out 32: muxed data-memory port.
- `dmem_rdata` in 32: data-memory read data.

## Operation
- FSM states: LOAD, RD_WAIT, RUN, DONE.
- LOAD (reset state):
  - `cpu_rst`=1, `host_ready`=1, host owns dmem.
  - WR_I: `imem_wr`=1 for that cycle, with `imem_addr`=`host_addr` and `imem_wdata`=`host_wdata[11:0]`.
  - WR_D: `dmem_wr`=1 for that cycle, with `host_addr` and `host_wdata`.
  - RD_D: drive `dmem_addr`, go to RD_WAIT.
  - RUN: clear `cycle_count` and `timeout`, go to RUN.
- RD_WAIT:
  - `host_ready`=0.
  - After `RD_LAT` cycles: `rd_valid`=1, `rd_data`=`dmem_rdata`; return to the originating state (LOAD or DONE).
- RUN:
  - `cpu_rst`=0, `host_ready`=0.
  - dmem port driven combinationally from `cpu_mem_*`.
  - `cycle_count` increments each RUN cycle.
  - Stability counter: cleared when `cpu_instr_addr` differs from its registered previous value, else increments.
  - Stability counter reaches `HALT_CYCLES` → DONE, `done` pulse.
  - `cycle_count` reaches `MAX_CYCLES` → DONE, `done` pulse, `timeout`=1.
  - Halt and budget in the same cycle: halt wins, `timeout` stays 0.
- DONE:
  - `cpu_rst`=1, `host_ready`=1, host owns dmem.
  - Same command set as LOAD; RUN restarts the processor from reset.
- Host writes are never issued in RUN. The processor never sees memory while `cpu_rst`=1.
- Counters saturate: `cycle_count` at 2^32-1, stability counter at `HALT_CYCLES`.

## Timing
- Reset values:
  - `cpu_rst`=1, `host_ready`=1 (state LOAD).
  - `rd_valid`, `done`, `timeout`, `imem_wr`, `dmem_wr` = 0.
  - `cycle_count`=0, `rd_data`=0.
- Write commands take effect in the acceptance cycle, with zero latency to the memory port.
- RD_D acceptance at cycle t → `rd_valid` at t+`RD_LAT`+1. `host_ready` low for `RD_LAT`+1 cycles.
- RUN acceptance at t → `cpu_rst` low from t+1.
- `done` asserts in the cycle after the last RUN cycle; `cpu_rst` returns high in the same cycle.
- `rst` mid-run: next cycle in LOAD, `cpu_rst`=1, all counters and flags cleared; memory contents untouched.
- The data-memory mux select is registered state, so it never changes within a cycle.

## Structure
- Package `sys_ctrl_pkg`:
  - command enum (WR_I, WR_D, RD_D, RUN);
  - state enum;
  - address width 8, instruction width 12, data width 32.
- Optional sub-module `halt_detect`: previous-address register plus stability counter, output `halted`.
- Everything else lives in one module.

## Test plan
- WR_I addr 5 data 0xABC → `imem_wr` pulse with `imem_addr`=5, `imem_wdata`=0xABC; `cpu_rst` stays 1.
- WR_D addr 3 data 0x12345678, then RD_D addr 3 → `rd_valid` 2 cycles after RD_D acceptance (`RD_LAT`=1), `rd_data`=0x12345678.
- Load a program that jumps to itself at addr 7, then RUN → `done` when addr 7 is held for 4 cycles, `timeout`=0, `cycle_count` matches the reference count.
- Load an infinite loop spanning 2 addresses, `MAX_CYCLES`=50 → `done` after 50 RUN cycles, `timeout`=1, `cycle_count`=50.
- Assert `rst` during RUN at cycle 10 → next cycle: state LOAD, `cpu_rst`=1, `cycle_count`=0, `host_ready`=1.
- Processor stores 42 to addr 9 during RUN, then host RD_D addr 9 in DONE → `rd_data`=42; `host_valid` during RUN is never accepted.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared types and widths for the run controller.
// Command encoding matches the host protocol.
package sys_ctrl_pkg;

  localparam int AW = 8;
  localparam int IW = 12;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    CMD_WR_I = 2'd0,
    CMD_WR_D = 2'd1,
    CMD_RD_D = 2'd2,
    CMD_RUN  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RD_WAIT,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sys_ctrl_halt_detect.sv
// Jump-to-self detector: counts cycles the fetch
// address stays unchanged, saturating at HALT_CYCLES.
module halt_detect
  import sys_ctrl_pkg::*;
#(
  parameter int HALT_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  output logic          o_halted
);

  localparam int SW = $clog2(HALT_CYCLES + 1);

  logic [AW-1:0] r_prev;
  logic          r_vld;
  logic [SW-1:0] r_stab;
  logic          w_same;
  logic [SW-1:0] w_stab_next;

  // First cycle of a run has no valid previous address.
  assign w_same = r_vld && (i_addr == r_prev);

  always_comb begin
    w_stab_next = '0;
    if (w_same) begin
      if (r_stab == SW'(HALT_CYCLES))
        w_stab_next = r_stab;
      else
        w_stab_next = r_stab + SW'(1);
    end
  end

  assign o_halted = i_en &&
    (w_stab_next == SW'(HALT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_prev <= '0;
      r_vld  <= 1'b0;
      r_stab <= '0;
    end else if (i_en) begin
      r_prev <= i_addr;
      r_vld  <= 1'b1;
      r_stab <= w_stab_next;
    end
  end

endmodule

// File: rtl/sys_ctrl.sv
// Run controller: host load/read-back around a
// bounded processor run with halt detection.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 1000,
  parameter int RD_LAT      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [1:0]    host_cmd,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          timeout,
  output logic [31:0]   cycle_count,
  output logic          cpu_rst,
  input  logic [AW-1:0] cpu_instr_addr,
  input  logic          cpu_mem_wr,
  input  logic [AW-1:0] cpu_mem_addr,
  input  logic [DW-1:0] cpu_mem_data,
  output logic          imem_wr,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          dmem_wr,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata
);

  state_e        r_state;
  state_e        w_next;
  state_e        r_ret;
  cmd_e          w_cmd;
  logic          w_host_st;
  logic          w_in_run;
  logic          w_acc;
  logic          w_rd_acc;
  logic          w_run_acc;
  logic          w_halt;
  logic          w_budget;
  logic          w_finish;
  logic          w_cap;
  logic [7:0]    r_wait;
  logic [AW-1:0] r_rd_addr;
  logic [31:0]   r_cycle;
  logic [31:0]   w_cnt_inc;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;
  logic          r_done;
  logic          r_timeout;

  assign w_cmd     = cmd_e'(host_cmd);
  assign w_host_st = (r_state == ST_LOAD) ||
                     (r_state == ST_DONE);
  assign w_in_run  = (r_state == ST_RUN);
  assign w_acc     = host_valid && w_host_st;
  assign w_rd_acc  = w_acc && (w_cmd == CMD_RD_D);
  assign w_run_acc = w_acc && (w_cmd == CMD_RUN);

  assign w_cnt_inc = (r_cycle == '1) ?
    r_cycle : r_cycle + 32'd1;
  assign w_budget  = w_in_run &&
    (w_cnt_inc >= 32'(MAX_CYCLES));
  assign w_finish  = w_in_run && (w_halt || w_budget);

  // Capture read data in the cycle it leaves the memory.
  assign w_cap = (RD_LAT == 0) ? w_rd_acc :
    ((r_state == ST_RD_WAIT) &&
     (r_wait == 8'(RD_LAT - 1)));

  halt_detect #(
    .HALT_CYCLES(HALT_CYCLES)
  ) u_halt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_run_acc),
    .i_en     (w_in_run),
    .i_addr   (cpu_instr_addr),
    .o_halted (w_halt)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD, ST_DONE: begin
        if (w_rd_acc)
          w_next = ST_RD_WAIT;
        else if (w_run_acc)
          w_next = ST_RUN;
      end
      ST_RD_WAIT: begin
        if (r_wait == 8'(RD_LAT))
          w_next = r_ret;
      end
      ST_RUN: begin
        if (w_finish)
          w_next = ST_DONE;
      end
      default: w_next = ST_LOAD;
    endcase
  end

  // Memory port ownership follows registered state only.
  always_comb begin
    cpu_rst    = 1'b1;
    host_ready = 1'b0;
    imem_wr    = 1'b0;
    imem_addr  = host_addr;
    imem_wdata = host_wdata[IW-1:0];
    dmem_wr    = 1'b0;
    dmem_addr  = host_addr;
    dmem_wdata = host_wdata;
    unique case (1'b1)
      w_in_run: begin
        cpu_rst    = 1'b0;
        dmem_wr    = cpu_mem_wr;
        dmem_addr  = cpu_mem_addr;
        dmem_wdata = cpu_mem_data;
      end
      (r_state == ST_RD_WAIT): begin
        dmem_addr = r_rd_addr;
      end
      default: begin
        host_ready = 1'b1;
        imem_wr = w_acc && (w_cmd == CMD_WR_I);
        dmem_wr = w_acc && (w_cmd == CMD_WR_D);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_LOAD;
      r_ret      <= ST_LOAD;
      r_wait     <= 8'd0;
      r_rd_addr  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_cycle    <= 32'd0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= w_cap;
      r_done     <= w_finish;
      if (w_cap)
        r_rd_data <= dmem_rdata;
      if (w_rd_acc) begin
        r_ret     <= r_state;
        r_rd_addr <= host_addr;
      end
      if (r_state == ST_RD_WAIT)
        r_wait <= r_wait + 8'd1;
      else
        r_wait <= 8'd0;
      if (w_run_acc) begin
        r_cycle   <= 32'd0;
        r_timeout <= 1'b0;
      end else if (w_in_run) begin
        r_cycle <= w_cnt_inc;
        // A halt in the budget cycle is a clean finish.
        if (w_budget && !w_halt)
          r_timeout <= 1'b1;
      end
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl with a toy processor
// and a one-cycle-latency data memory model.
module tb_sys_ctrl;
  import sys_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_valid;
  logic        host_ready;
  logic [1:0]  host_cmd;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;
  logic        cpu_rst;
  logic [7:0]  cpu_instr_addr;
  logic        cpu_mem_wr;
  logic [7:0]  cpu_mem_addr;
  logic [31:0] cpu_mem_data;
  logic        imem_wr;
  logic [7:0]  imem_addr;
  logic [11:0] imem_wdata;
  logic        dmem_wr;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  int n_err = 0;
  int n_chk = 0;

  sys_ctrl #(
    .HALT_CYCLES(4),
    .MAX_CYCLES (50),
    .RD_LAT     (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .host_cmd      (host_cmd),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .done          (done),
    .timeout       (timeout),
    .cycle_count   (cycle_count),
    .cpu_rst       (cpu_rst),
    .cpu_instr_addr(cpu_instr_addr),
    .cpu_mem_wr    (cpu_mem_wr),
    .cpu_mem_addr  (cpu_mem_addr),
    .cpu_mem_data  (cpu_mem_data),
    .imem_wr       (imem_wr),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .dmem_wr       (dmem_wr),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, one-cycle read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (dmem_wr)
      mem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= mem[dmem_addr];
  end

  // Toy processor: mode 0 counts up to tgt and jumps
  // to self; mode 1 bounces between 0 and 1 forever.
  // At pc 3 it stores 42 to address 9.
  logic       mode;
  logic [7:0] tgt;
  logic [7:0] pc;
  always @(posedge clk) begin
    if (cpu_rst)
      pc <= 8'd0;
    else if (mode)
      pc <= (pc == 8'd0) ? 8'd1 : 8'd0;
    else
      pc <= (pc == tgt) ? pc : pc + 8'd1;
  end
  always_comb begin
    cpu_instr_addr = pc;
    cpu_mem_wr     = !cpu_rst && (pc == 8'd3);
    cpu_mem_addr   = 8'd9;
    cpu_mem_data   = 32'd42;
  end

  typedef struct {
    cmd_e        cmd;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        iwr;
    logic        dwr;
    logic [11:0] iwd;
    logic [31:0] rd;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic do_rd(input logic [7:0] a,
                       input logic [31:0] exp,
                       input string nm);
    host_valid = 1'b1;
    host_cmd   = CMD_RD_D;
    host_addr  = a;
    #1;
    chk({nm, "_ready"}, 32'(host_ready), 32'd1);
    chk({nm, "_addr"}, 32'(dmem_addr), 32'(a));
    tick();
    host_valid = 1'b0;
    chk({nm, "_busy1"}, 32'(host_ready), 32'd0);
    chk({nm, "_early"}, 32'(rd_valid), 32'd0);
    tick();
    chk({nm, "_valid"}, 32'(rd_valid), 32'd1);
    chk({nm, "_data"}, rd_data, exp);
    chk({nm, "_busy2"}, 32'(host_ready), 32'd0);
    tick();
    chk({nm, "_pulse"}, 32'(rd_valid), 32'd0);
    chk({nm, "_back"}, 32'(host_ready), 32'd1);
  endtask

  // Issue RUN, hold a stray WR_D on the host port
  // during the run, and count RUN cycles until done.
  task automatic run_prog(input logic m,
                          input logic [7:0] t,
                          input int stop_at,
                          output int ncyc,
                          output logic got);
    int n_rdy;
    mode       = m;
    tgt        = t;
    host_valid = 1'b1;
    host_cmd   = CMD_RUN;
    tick();
    chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("run_clr_cnt", cycle_count, 32'd0);
    chk("run_clr_to", 32'(timeout), 32'd0);
    host_cmd   = CMD_WR_D;
    host_addr  = 8'd9;
    host_wdata = 32'h77;
    ncyc  = 0;
    n_rdy = 0;
    got   = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (!cpu_rst) ncyc++;
      if (host_ready) n_rdy++;
      if (stop_at > 0 && ncyc == stop_at) begin
        rst = 1'b1;
        break;
      end
      tick();
    end
    host_valid = 1'b0;
    chk("run_no_accept", 32'(n_rdy), 32'd0);
  endtask

  int   ncyc;
  logic got;

  initial begin
    vecs[0] = '{CMD_WR_I, 8'd5, 32'h0000_0ABC,
                1'b1, 1'b0, 12'hABC, 32'h0};
    vecs[1] = '{CMD_WR_D, 8'd3, 32'h1234_5678,
                1'b0, 1'b1, 12'h0, 32'h0};
    vecs[2] = '{CMD_WR_I, 8'd255, 32'hFFFF_F123,
                1'b1, 1'b0, 12'h123, 32'h0};
    vecs[3] = '{CMD_WR_D, 8'd0, 32'hDEAD_BEEF,
                1'b0, 1'b1, 12'h0, 32'h0};
    vecs[4] = '{CMD_RD_D, 8'd3, 32'h0,
                1'b0, 1'b0, 12'h0, 32'h1234_5678};
    vecs[5] = '{CMD_RD_D, 8'd0, 32'h0,
                1'b0, 1'b0, 12'h0, 32'hDEAD_BEEF};
    vecs[6] = '{CMD_WR_D, 8'd3, 32'h0,
                1'b0, 1'b1, 12'h0, 32'h0};
    vecs[7] = '{CMD_RD_D, 8'd3, 32'h0,
                1'b0, 1'b0, 12'h0, 32'h0};

    rst        = 1'b1;
    host_valid = 1'b0;
    host_cmd   = CMD_WR_I;
    host_addr  = 8'd0;
    host_wdata = 32'd0;
    mode       = 1'b0;
    tgt        = 8'd7;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_ready", 32'(host_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_imem_wr", 32'(imem_wr), 32'd0);
    chk("rst_dmem_wr", 32'(dmem_wr), 32'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].cmd == CMD_RD_D) begin
        do_rd(vecs[i].addr, vecs[i].rd, "vec_rd");
      end else begin
        host_valid = 1'b1;
        host_cmd   = vecs[i].cmd;
        host_addr  = vecs[i].addr;
        host_wdata = vecs[i].wd;
        #1;
        chk("vec_ready", 32'(host_ready), 32'd1);
        chk("vec_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("vec_imem_wr", 32'(imem_wr),
            32'(vecs[i].iwr));
        chk("vec_dmem_wr", 32'(dmem_wr),
            32'(vecs[i].dwr));
        if (vecs[i].iwr) begin
          chk("vec_imem_addr", 32'(imem_addr),
              32'(vecs[i].addr));
          chk("vec_imem_wdata", 32'(imem_wdata),
              32'(vecs[i].iwd));
        end
        if (vecs[i].dwr) begin
          chk("vec_dmem_addr", 32'(dmem_addr),
              32'(vecs[i].addr));
          chk("vec_dmem_wdata", dmem_wdata,
              vecs[i].wd);
        end
        tick();
        host_valid = 1'b0;
        #1;
        chk("vec_wr_once", 32'(imem_wr | dmem_wr),
            32'd0);
      end
    end

    // Jump-to-self at 7: fetch 0..7, then 4 stable.
    run_prog(1'b0, 8'd7, 0, ncyc, got);
    chk("halt_done", 32'(got), 32'd1);
    chk("halt_ncyc", 32'(ncyc), 32'd12);
    chk("halt_count", cycle_count, 32'd12);
    chk("halt_timeout", 32'(timeout), 32'd0);
    chk("halt_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("halt_ready", 32'(host_ready), 32'd1);
    tick();
    chk("halt_pulse", 32'(done), 32'd0);
    do_rd(8'd9, 32'd42, "cpu_store");

    // Two-address loop runs into the budget.
    run_prog(1'b1, 8'd0, 0, ncyc, got);
    chk("budget_done", 32'(got), 32'd1);
    chk("budget_ncyc", 32'(ncyc), 32'd50);
    chk("budget_count", cycle_count, 32'd50);
    chk("budget_timeout", 32'(timeout), 32'd1);
    tick();
    tick();
    chk("budget_sticky", 32'(timeout), 32'd1);
    chk("budget_pulse", 32'(done), 32'd0);

    // Halt lands exactly on the budget cycle.
    run_prog(1'b0, 8'd45, 0, ncyc, got);
    chk("tie_done", 32'(got), 32'd1);
    chk("tie_ncyc", 32'(ncyc), 32'd50);
    chk("tie_count", cycle_count, 32'd50);
    chk("tie_timeout", 32'(timeout), 32'd0);
    tick();

    // Reset in the 10th RUN cycle.
    run_prog(1'b1, 8'd0, 10, ncyc, got);
    chk("mid_ncyc", 32'(ncyc), 32'd10);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mid_count", cycle_count, 32'd0);
    chk("mid_ready", 32'(host_ready), 32'd1);
    chk("mid_timeout", 32'(timeout), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    do_rd(8'd9, 32'd42, "mid_mem");

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
